multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Parametrised successor to the single-cycle main decoder: a Moore FSM that sequences the RISC-V multicycle datapath (fetch, decode, execute, memory, writeback) over several clocks.
- Instruction set: lw, sw, R-type, beq, I-type ALU and jal.
- Adds wait states on a memory-ready handshake and an illegal-opcode trap.
- Sits in control_unit beside the ALU decoder, which consumes ALUOp; it drives the PC, IR, register file and memory enables.

Parameters:
- SUPPORT_ITYPE, 1, enables opcode 0010011 (addi-class). When 0, that opcode decodes as illegal.
- SUPPORT_JAL, 1, enables opcode 1101111. When 0, that opcode decodes as illegal.
- USE_MEM_READY, 1, when 0 the mem_ready input is ignored and treated as constant 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  opcode from the instruction register; stable from DECODE until the next FETCH
- mem_ready  in  1  memory has completed the access this cycle
- IRWrite  out  1  instruction register load
- PCUpdate  out  1  unconditional PC load
- Branch  out  1  PC load qualified externally by Zero
- RegWrite  out  1  register file write
- MemWrite  out  1  data memory write
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- illegal_instr  out  1  one-cycle pulse on an undecodable opcode
- fsm_state  out  4  current state, for debug and the testbench

Behaviour:
- Clock and reset: single clock domain clk; reset is synchronous and active-high.
- Reset: on any rising edge with reset=1 the state becomes FETCH. While reset=1, all enables are 0 (IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal_instr) and all selects are 0. Reset mid-instruction aborts it and causes no writes.
- Outputs are decoded from state only (Moore), except ImmSrc, which is combinational from op. Every unlisted output is 0 in each state.
- ImmSrc by opcode:
  - 0000011 and 0010011: 00
  - 0100011: 01
  - 1100011: 10
  - 1101111: 11
  - anything else: 00
- States (4-bit encoding 0..11) and transitions:
  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate are asserted only when mem_ready=1. Goes to DECODE when mem_ready=1, otherwise stays in FETCH.
  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
    - lw or sw: MEMADR
    - R-type: EXECR
    - 0010011: EXECI
    - 1101111: JAL
    - 1100011: BEQ
    - anything else: TRAP
  - MEMADR(2): ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): AdrSrc=1, ResultSrc=00. Goes to MEMWB when mem_ready=1, otherwise stays.
  - MEMWB(4): ResultSrc=01, RegWrite=1. Goes to FETCH.
  - MEMWRITE(5): AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready=1. Goes to FETCH on mem_ready=1.
  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1. Goes to FETCH.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
  - BEQ(10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
  - TRAP(11): illegal_instr=1. Goes to FETCH.
- Unused encodings (12..15) go to FETCH, with all outputs 0.
- Cycle counts with mem_ready=1 throughout, FETCH included:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - illegal: 3
- Each stalled cycle of mem_ready adds 1 to these counts.
- Invariants: RegWrite and MemWrite are never both 1. PCUpdate and Branch are never both 1.

Decomposition:
- Shared package control_pkg:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - state localparams S_FETCH..S_TRAP
  - select encodings (ALUSRCA_*, ALUSRCB_*, RESULT_*, IMM_*)
- Sub-module: imm_src_decoder, the combinational op-to-ImmSrc map, reusable by the single-cycle path.

Test Plan:
- Reset is 1 for 2 cycles, then released. Expected: fsm_state=0 and all enables 0 during reset; the first cycle after release shows FETCH outputs with IRWrite=PCUpdate=1.
- op=0000011, mem_ready=1. Expected: states 0,1,2,3,4,0; RegWrite=1 only in state 4; ResultSrc=01 there.
- op=0100011, mem_ready low for 3 cycles in MEMWRITE. Expected: MemWrite stays 1 for 4 cycles, then FETCH; RegWrite never 1.
- op=1100011. Expected: states 0,1,10,0; Branch=1 with ALUOp=01 in state 10; ImmSrc=10.
- op=1101111 with SUPPORT_JAL=1. Expected: states 0,1,9,8,0 with PCUpdate=1 in state 9. With SUPPORT_JAL=0: states 0,1,11,0 with a single illegal_instr pulse.
- Reset asserted while in MEMREAD. Expected: next state 0, no RegWrite pulse; stalling mem_ready in FETCH holds IRWrite=0 and the state at 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control path: opcodes, FSM states,
// datapath select codes and the per-state control word.
package control_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUSRCA_PC    = 2'b00;
    localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
    localparam logic [1:0] ALUSRCA_RS1   = 2'b10;

    localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // gate: irwrite/pcupdate in this state only fire once memory is ready
    typedef struct packed {
        logic       irwrite;
        logic       pcupdate;
        logic       gate;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       illegal;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] resultsrc;
    } ctrl_t;

    // Moore control word for each state; unused encodings yield all zeros
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.pcupdate  = 1'b1;
                c.gate      = 1'b1;
                c.alusrca   = ALUSRCA_PC;
                c.alusrcb   = ALUSRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.resultsrc = RESULT_ALURESULT;
            end
            S_DECODE: begin
                c.alusrca = ALUSRCA_OLDPC;
                c.alusrcb = ALUSRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alusrca = ALUSRCA_RS1;
                c.alusrcb = ALUSRCB_IMM;
            end
            S_MEMREAD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RESULT_ALUOUT;
            end
            S_MEMWB: begin
                c.resultsrc = RESULT_DATA;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RESULT_ALUOUT;
                c.memwrite  = 1'b1;
            end
            S_EXECR: begin
                c.alusrca = ALUSRCA_RS1;
                c.alusrcb = ALUSRCB_RS2;
                c.aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alusrca = ALUSRCA_RS1;
                c.alusrcb = ALUSRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.resultsrc = RESULT_ALUOUT;
                c.regwrite  = 1'b1;
            end
            S_JAL: begin
                c.alusrca   = ALUSRCA_OLDPC;
                c.alusrcb   = ALUSRCB_FOUR;
                c.resultsrc = RESULT_ALUOUT;
                c.pcupdate  = 1'b1;
            end
            S_BEQ: begin
                c.alusrca   = ALUSRCA_RS1;
                c.alusrcb   = ALUSRCB_RS2;
                c.aluop     = ALUOP_SUB;
                c.resultsrc = RESULT_ALUOUT;
                c.branch    = 1'b1;
            end
            S_TRAP: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format map; shared with the single-cycle decoder.
module imm_src_decoder
    import control_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    // pure lookup, unknown opcodes fall back to I-format
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RISC-V datapath. The control word is
// registered alongside the state so outputs come straight from flops; only
// the FETCH strobes are qualified by mem_ready and everything is forced to
// zero while reset is high.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter bit SUPPORT_ITYPE = 1'b1,
    parameter bit SUPPORT_JAL   = 1'b1,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       illegal_instr,
    output logic [3:0] fsm_state
);

    state_t     state;
    ctrl_t      ctrl_q;
    logic       rdy;
    logic [1:0] imm_sel;

    assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

    function automatic state_t next_state(state_t s, logic [6:0] o, logic r);
        state_t n;
        case (s)
            S_FETCH:    n = r ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (o == OP_LW || o == OP_SW)        n = S_MEMADR;
                else if (o == OP_R)                  n = S_EXECR;
                else if (o == OP_I && SUPPORT_ITYPE) n = S_EXECI;
                else if (o == OP_JAL && SUPPORT_JAL) n = S_JAL;
                else if (o == OP_BEQ)                n = S_BEQ;
                else                                 n = S_TRAP;
            end
            S_MEMADR:   n = (o == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  n = r ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    n = S_FETCH;
            S_MEMWRITE: n = r ? S_FETCH : S_MEMWRITE;
            S_EXECR:    n = S_ALUWB;
            S_EXECI:    n = S_ALUWB;
            S_ALUWB:    n = S_FETCH;
            S_JAL:      n = S_ALUWB;
            S_BEQ:      n = S_FETCH;
            S_TRAP:     n = S_FETCH;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    // state and its control word advance together
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= next_state(state, op, rdy);
            ctrl_q <= state_ctrl(next_state(state, op, rdy));
        end
    end

    imm_src_decoder u_imm (
        .op      (op),
        .imm_src (imm_sel)
    );

    // an aborted instruction must not write anything during reset
    assign IRWrite       = ~reset & ctrl_q.irwrite & (rdy | ~ctrl_q.gate);
    assign PCUpdate      = ~reset & ctrl_q.pcupdate & (rdy | ~ctrl_q.gate);
    assign Branch        = ~reset & ctrl_q.branch;
    assign RegWrite      = ~reset & ctrl_q.regwrite;
    assign MemWrite      = ~reset & ctrl_q.memwrite;
    assign illegal_instr = ~reset & ctrl_q.illegal;
    assign AdrSrc        = ~reset & ctrl_q.adrsrc;
    assign ALUSrcA       = reset ? 2'b00 : ctrl_q.alusrca;
    assign ALUSrcB       = reset ? 2'b00 : ctrl_q.alusrcb;
    assign ALUOp         = reset ? 2'b00 : ctrl_q.aluop;
    assign ResultSrc     = reset ? 2'b00 : ctrl_q.resultsrc;
    assign ImmSrc        = reset ? IMM_I : imm_sel;
    assign fsm_state     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: default-parameter DUT walks every instruction class;
// a second DUT with I-type/JAL/ready support disabled checks the traps and
// the ignored handshake.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;

    logic       IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, illegal_instr;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
    logic [3:0] fsm_state;

    logic       IRWrite2, PCUpdate2, Branch2, RegWrite2, MemWrite2, AdrSrc2, illegal2;
    logic [1:0] ALUSrcA2, ALUSrcB2, ALUOp2, ResultSrc2, ImmSrc2;
    logic [3:0] fsm_state2;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] exp_st  [8];
    logic       exp_rdy [8];

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .illegal_instr(illegal_instr), .fsm_state(fsm_state)
    );

    multicycle_control_fsm #(
        .SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b0), .USE_MEM_READY(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .IRWrite(IRWrite2), .PCUpdate(PCUpdate2), .Branch(Branch2),
        .RegWrite(RegWrite2), .MemWrite(MemWrite2), .AdrSrc(AdrSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
        .ResultSrc(ResultSrc2), .ImmSrc(ImmSrc2),
        .illegal_instr(illegal2), .fsm_state(fsm_state2)
    );

    logic [5:0] en, en2;
    logic [8:0] sel, sel2;
    assign en   = {IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal_instr};
    assign en2  = {IRWrite2, PCUpdate2, Branch2, RegWrite2, MemWrite2, illegal2};
    assign sel  = {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc};
    assign sel2 = {AdrSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, ResultSrc2};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // enables {IRWrite,PCUpdate,Branch,RegWrite,MemWrite,illegal} per state
    function automatic logic [5:0] exp_en(logic [3:0] s, logic r);
        case (s)
            4'd0:       return r ? 6'b110000 : 6'b000000;
            4'd4, 4'd8: return 6'b000100;
            4'd5:       return 6'b000010;
            4'd9:       return 6'b010000;
            4'd10:      return 6'b001000;
            4'd11:      return 6'b000001;
            default:    return 6'b000000;
        endcase
    endfunction

    // selects {AdrSrc,ALUSrcA,ALUSrcB,ALUOp,ResultSrc} per state
    function automatic logic [8:0] exp_sel(logic [3:0] s);
        case (s)
            4'd0:       return 9'b0_00_10_00_10;
            4'd1:       return 9'b0_01_01_00_00;
            4'd2:       return 9'b0_10_01_00_00;
            4'd3, 4'd5: return 9'b1_00_00_00_00;
            4'd4:       return 9'b0_00_00_00_01;
            4'd6:       return 9'b0_10_00_10_00;
            4'd7:       return 9'b0_10_01_10_00;
            4'd9:       return 9'b0_01_10_00_00;
            4'd10:      return 9'b0_10_00_01_00;
            default:    return 9'b0_00_00_00_00;
        endcase
    endfunction

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    // walk n cycles of one instruction against exp_st/exp_rdy, starting in FETCH
    task automatic run_seq(input string tag, input logic [6:0] o, input logic [1:0] imm,
                           input int n, input bit d2);
        op = o;
        for (int i = 0; i < n; i++) begin
            mem_ready = exp_rdy[i];
            #1;
            chk({tag, "_st"},  {12'd0, d2 ? fsm_state2 : fsm_state}, {12'd0, exp_st[i]});
            chk({tag, "_en"},  {10'd0, d2 ? en2 : en}, {10'd0, exp_en(exp_st[i], d2 ? 1'b1 : exp_rdy[i])});
            chk({tag, "_sel"}, {7'd0, d2 ? sel2 : sel}, {7'd0, exp_sel(exp_st[i])});
            chk({tag, "_inv"}, {14'd0, RegWrite & MemWrite, PCUpdate & Branch}, 16'd0);
            if (i == 1) chk({tag, "_imm"}, {14'd0, d2 ? ImmSrc2 : ImmSrc}, {14'd0, imm});
            if (i < n - 1) nxt();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; op = 7'd0; mem_ready = 1'b1;
        nxt();
        chk("rst_st", {12'd0, fsm_state}, 16'd0);
        chk("rst_en", {10'd0, en}, 16'd0);
        chk("rst_sel", {5'd0, sel, ImmSrc}, 16'd0);
        nxt();
        chk("rst_st2", {12'd0, fsm_state}, 16'd0);
        chk("rst_en2", {10'd0, en}, 16'd0);
        reset = 1'b0;
        #1;
        chk("rel_en", {10'd0, en}, 16'h30);
        chk("rel_sel", {7'd0, sel}, {7'd0, 9'b0_00_10_00_10});

        exp_st = '{0, 1, 2, 3, 4, 0, 0, 0}; exp_rdy = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_seq("lw", 7'b0000011, 2'b00, 6, 1'b0);

        exp_st = '{0, 1, 2, 5, 5, 5, 5, 0}; exp_rdy = '{1, 1, 1, 0, 0, 0, 1, 1};
        run_seq("sw", 7'b0100011, 2'b01, 8, 1'b0);

        exp_st = '{0, 1, 6, 8, 0, 0, 0, 0}; exp_rdy = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_seq("rtype", 7'b0110011, 2'b00, 5, 1'b0);

        exp_st = '{0, 1, 7, 8, 0, 0, 0, 0};
        run_seq("itype", 7'b0010011, 2'b00, 5, 1'b0);

        exp_st = '{0, 1, 10, 0, 0, 0, 0, 0};
        run_seq("beq", 7'b1100011, 2'b10, 4, 1'b0);

        exp_st = '{0, 1, 9, 8, 0, 0, 0, 0};
        run_seq("jal", 7'b1101111, 2'b11, 5, 1'b0);

        exp_st = '{0, 1, 11, 0, 0, 0, 0, 0};
        run_seq("illegal", 7'b1111111, 2'b00, 4, 1'b0);

        // abort a stalled load with reset
        exp_st = '{0, 1, 2, 3, 0, 0, 0, 0}; exp_rdy = '{1, 1, 1, 0, 1, 1, 1, 1};
        run_seq("lwabort", 7'b0000011, 2'b00, 4, 1'b0);
        reset = 1'b1;
        #1;
        chk("abort_en", {10'd0, en}, 16'd0);
        chk("abort_sel", {7'd0, sel}, 16'd0);
        nxt();
        #1;
        chk("abort_st", {12'd0, fsm_state}, 16'd0);
        chk("abort_en2", {10'd0, en}, 16'd0);

        // FETCH stall; the ready-agnostic instance fetches anyway
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk("fstall_en", {10'd0, en}, 16'd0);
        chk("noready_en", {10'd0, en2}, 16'h30);
        nxt();
        #1;
        chk("fstall_st", {12'd0, fsm_state}, 16'd0);
        chk("fstall_en2", {10'd0, en}, 16'd0);
        chk("noready_st", {12'd0, fsm_state2}, 16'd1);
        mem_ready = 1'b1;
        #1;
        chk("fstall_go", {10'd0, en}, 16'h30);

        // restricted instance: jal and addi-class both trap
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        exp_st = '{0, 1, 11, 0, 0, 0, 0, 0}; exp_rdy = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_seq("jal_off", 7'b1101111, 2'b11, 4, 1'b1);
        run_seq("itype_off", 7'b0010011, 2'b00, 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
